// File: rtl/pc_next_unit.sv
// ----------------------------------------------------------------------------
// pc_next_unit
//
// Purpose:
//   Program-counter sequencer for a 16-bit fetch stage. Each cycle it picks the
//   next fetch address from the highest-priority request and tracks the
//   START / RUN / FLUSH / HALTED control state.
//
//   Request priority (highest first):
//     rst > halt > jmp > br_taken > stall > sequential increment
//
//   Handshake note: this block has no valid/ready channels. Requests are
//   level-sampled on every rising edge, and pc/pc_valid are valid from the
//   edge that produced them. A consumer must treat pc as a real fetch address
//   only while pc_valid=1, and must drop the instruction fetched one cycle
//   earlier whenever flush=1.
//
// Ports:
//   clk       in   1   rising-edge clock
//   rst       in   1   synchronous reset, active-high
//   stall     in   1   hold pc this cycle
//   halt      in   1   enter HALTED
//   resume    in   1   leave HALTED
//   br_taken  in   1   relative branch request
//   br_off    in  16   signed byte offset, added to the current pc
//   jmp       in   1   absolute jump request
//   jmp_tgt   in  16   absolute jump target
//   pc        out 16   current fetch address (registered)
//   pc_valid  out  1   pc is a real fetch address (registered)
//   flush     out  1   squash the instruction fetched last cycle (registered)
//   misalign  out  1   one-cycle pulse after an accepted odd jump (registered)
//   state     out  2   START=00, RUN=01, FLUSH=10, HALTED=11
// ----------------------------------------------------------------------------
module pc_next_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] INC      = 16'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        halt,
    input  logic        resume,
    input  logic        br_taken,
    input  logic [15:0] br_off,
    input  logic        jmp,
    input  logic [15:0] jmp_tgt,
    output logic [15:0] pc,
    output logic        pc_valid,
    output logic        flush,
    output logic        misalign,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_START  = 2'b00,
        ST_RUN    = 2'b01,
        ST_FLUSH  = 2'b10,
        ST_HALTED = 2'b11
    } state_t;

    state_t      cur_state;
    state_t      nxt_state;
    logic [15:0] cur_pc;
    logic [15:0] nxt_pc;
    logic        cur_flush;
    logic        nxt_flush;
    logic        cur_misalign;
    logic        nxt_misalign;

    // Candidate addresses, computed once and selected by the FSM below.
    logic [15:0] seq_pc;
    logic [15:0] br_pc;
    logic [15:0] jmp_pc;

    assign seq_pc = cur_pc + INC;       // wraps modulo 2^16
    assign br_pc  = cur_pc + br_off;    // two's complement add == signed offset
    assign jmp_pc = {jmp_tgt[15:1], 1'b0};

    // ------------------------------------------------------------------------
    // State / datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state    <= ST_START;
            cur_pc       <= RESET_PC;
            cur_flush    <= 1'b0;
            cur_misalign <= 1'b0;
        end else begin
            cur_state    <= nxt_state;
            cur_pc       <= nxt_pc;
            cur_flush    <= nxt_flush;
            cur_misalign <= nxt_misalign;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state / next-pc logic
    // flush and misalign are single-cycle pulses, so they default to 0 and are
    // only raised on the cycle a redirect is accepted.
    // ------------------------------------------------------------------------
    always_comb begin
        nxt_state    = cur_state;
        nxt_pc       = cur_pc;
        nxt_flush    = 1'b0;
        nxt_misalign = 1'b0;

        unique case (cur_state)
            ST_START: begin
                // pc already holds RESET_PC; just open the fetch stream.
                if (halt) nxt_state = ST_HALTED;
                else      nxt_state = ST_RUN;
            end

            ST_RUN: begin
                if (halt) begin
                    nxt_state = ST_HALTED;
                end else if (jmp) begin
                    nxt_pc       = jmp_pc;
                    nxt_misalign = jmp_tgt[0];
                    nxt_flush    = 1'b1;
                    nxt_state    = ST_FLUSH;
                end else if (br_taken) begin
                    nxt_pc    = br_pc;
                    nxt_flush = 1'b1;
                    nxt_state = ST_FLUSH;
                end else if (!stall) begin
                    nxt_pc = seq_pc;
                end
            end

            ST_FLUSH: begin
                // Redirect requests seen here come from the squashed
                // instruction, so only halt and stall are honoured.
                if (halt) begin
                    nxt_state = ST_HALTED;
                end else begin
                    if (!stall) nxt_pc = seq_pc;
                    nxt_state = ST_RUN;
                end
            end

            ST_HALTED: begin
                if (resume && !halt) nxt_state = ST_RUN;
            end

            default: nxt_state = ST_START;
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // pc_valid is a pure decode of the registered state, so it is registered
    // by construction and can never disagree with state.
    // ------------------------------------------------------------------------
    assign pc       = cur_pc;
    assign pc_valid = (cur_state == ST_RUN) || (cur_state == ST_FLUSH);
    assign flush    = cur_flush;
    assign misalign = cur_misalign;
    assign state    = cur_state;

endmodule

// File: tb/tb_pc_next_unit.sv
// ----------------------------------------------------------------------------
// tb_pc_next_unit
//
// Self-checking bench for pc_next_unit. A behavioural model of the sequencing
// rules predicts every output after every clock edge; literal expectations
// taken from hand-worked scenarios pin the model at key points.
// ----------------------------------------------------------------------------
module tb_pc_next_unit;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [15:0] INC      = 16'd2;

    // Model state names (values match the documented state encoding)
    localparam logic [1:0] M_START  = 2'b00;
    localparam logic [1:0] M_RUN    = 2'b01;
    localparam logic [1:0] M_FLUSH  = 2'b10;
    localparam logic [1:0] M_HALTED = 2'b11;

    // ------------------------------------------------------------------------
    // Clock / reset block
    // ------------------------------------------------------------------------
    logic        clk = 1'b0;
    logic        rst;
    logic        stall, halt, resume, br_taken, jmp;
    logic [15:0] br_off, jmp_tgt;
    logic [15:0] pc;
    logic        pc_valid, flush, misalign;
    logic [1:0]  state;

    always #5 clk = ~clk;

    pc_next_unit #(.RESET_PC(RESET_PC), .INC(INC)) dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .halt     (halt),
        .resume   (resume),
        .br_taken (br_taken),
        .br_off   (br_off),
        .jmp      (jmp),
        .jmp_tgt  (jmp_tgt),
        .pc       (pc),
        .pc_valid (pc_valid),
        .flush    (flush),
        .misalign (misalign),
        .state    (state)
    );

    // ------------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------------
    logic [15:0] m_pc;
    logic        m_valid, m_flush, m_mis;
    logic [1:0]  m_state;
    bit          m_known = 0;   // model is only meaningful after first reset

    int vectors     = 0;
    int miscompares = 0;

    // Apply one edge's worth of rules to the model, using the current inputs.
    task automatic model_step();
        if (rst) begin
            m_pc = RESET_PC; m_valid = 0; m_flush = 0; m_mis = 0;
            m_state = M_START; m_known = 1;
        end else if (m_known) begin
            m_flush = 0;
            m_mis   = 0;
            if (m_state == M_START) begin
                m_state = halt ? M_HALTED : M_RUN;
            end else if (m_state == M_HALTED) begin
                if (resume && !halt) m_state = M_RUN;
            end else if (halt) begin
                m_state = M_HALTED;           // RUN or FLUSH: halt wins
            end else if (m_state == M_RUN && jmp) begin
                m_pc    = jmp_tgt & 16'hFFFE;
                m_mis   = jmp_tgt[0];
                m_flush = 1;
                m_state = M_FLUSH;
            end else if (m_state == M_RUN && br_taken) begin
                m_pc    = 16'((int'(m_pc) + int'($signed(br_off))) & 32'hFFFF);
                m_flush = 1;
                m_state = M_FLUSH;
            end else begin
                if (!stall) m_pc = 16'((int'(m_pc) + int'(INC)) % 65536);
                m_state = M_RUN;              // FLUSH lasts one cycle
            end
            m_valid = (m_state == M_RUN) || (m_state == M_FLUSH);
        end
    endtask

    // ------------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------------
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model.
    task automatic compare_all();
        chk("pc",       pc,               m_pc);
        chk("pc_valid", {15'd0, pc_valid}, {15'd0, m_valid});
        chk("flush",    {15'd0, flush},    {15'd0, m_flush});
        chk("misalign", {15'd0, misalign}, {15'd0, m_mis});
        chk("state",    {14'd0, state},    {14'd0, m_state});
    endtask

    // ------------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------------
    task automatic idle_inputs();
        rst = 0; stall = 0; halt = 0; resume = 0;
        br_taken = 0; br_off = 16'h0; jmp = 0; jmp_tgt = 16'h0;
    endtask

    // Inputs are set before the call (on the falling edge); one clock edge is
    // taken, the model advanced, and the outputs checked 1 time unit later.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        idle_inputs();
    endtask

    // Literal check of the full visible state after the last cycle.
    task automatic lit(input string name, input logic [15:0] e_pc, input logic e_valid,
                       input logic e_flush, input logic e_mis, input logic [1:0] e_state);
        chk({name, ".pc"},    pc,               e_pc);
        chk({name, ".valid"}, {15'd0, pc_valid}, {15'd0, e_valid});
        chk({name, ".flush"}, {15'd0, flush},    {15'd0, e_flush});
        chk({name, ".mis"},   {15'd0, misalign}, {15'd0, e_mis});
        chk({name, ".state"}, {14'd0, state},    {14'd0, e_state});
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        idle_inputs();
        @(negedge clk);

        // Reset then three idle cycles
        rst = 1; cycle();
        lit("reset", 16'h0000, 0, 0, 0, M_START);
        cycle(); lit("idle1", 16'h0000, 1, 0, 0, M_RUN);
        cycle(); lit("idle2", 16'h0002, 1, 0, 0, M_RUN);
        cycle(); lit("idle3", 16'h0004, 1, 0, 0, M_RUN);

        // Even jump to 000E (misalign must stay 0), then advance to 0010
        jmp = 1; jmp_tgt = 16'h000E; cycle();
        lit("jmp_even", 16'h000E, 1, 1, 0, M_FLUSH);
        cycle(); lit("after_jmp", 16'h0010, 1, 0, 0, M_RUN);

        // Backward branch 0010 + FFF0 -> 0000
        br_taken = 1; br_off = 16'hFFF0; cycle();
        lit("br_back", 16'h0000, 1, 1, 0, M_FLUSH);
        cycle(); lit("br_after", 16'h0002, 1, 0, 0, M_RUN);

        // Odd jump wins over simultaneous branch; branch in FLUSH ignored
        jmp = 1; jmp_tgt = 16'h1235; br_taken = 1; br_off = 16'h0040; cycle();
        lit("jmp_odd", 16'h1234, 1, 1, 1, M_FLUSH);
        br_taken = 1; br_off = 16'h0100; cycle();
        lit("flush_br_ign", 16'h1236, 1, 0, 0, M_RUN);

        // Wrap FFFE -> 0000, then stall three cycles
        jmp = 1; jmp_tgt = 16'hFFFD; cycle();
        lit("jmp_fffc", 16'hFFFC, 1, 1, 1, M_FLUSH);
        cycle(); lit("to_fffe", 16'hFFFE, 1, 0, 0, M_RUN);
        cycle(); lit("wrap", 16'h0000, 1, 0, 0, M_RUN);
        for (int i = 0; i < 3; i++) begin
            stall = 1; cycle();
            lit("stall", 16'h0000, 1, 0, 0, M_RUN);
        end

        // halt beats jmp; halt+resume stays halted; resume alone runs
        halt = 1; jmp = 1; jmp_tgt = 16'h4000; cycle();
        lit("halt_jmp", 16'h0000, 0, 0, 0, M_HALTED);
        halt = 1; resume = 1; cycle();
        lit("halt_resume", 16'h0000, 0, 0, 0, M_HALTED);
        resume = 1; cycle();
        lit("resume", 16'h0000, 1, 0, 0, M_RUN);
        cycle(); lit("post_resume", 16'h0002, 1, 0, 0, M_RUN);

        // Branch accepted during stall; stall during FLUSH holds pc
        stall = 1; br_taken = 1; br_off = 16'h0010; cycle();
        lit("br_stall", 16'h0012, 1, 1, 0, M_FLUSH);
        stall = 1; cycle();
        lit("flush_stall", 16'h0012, 1, 0, 0, M_RUN);

        // Halt during FLUSH
        jmp = 1; jmp_tgt = 16'h0101; cycle();
        halt = 1; cycle();
        lit("halt_in_flush", 16'h0100, 0, 0, 0, M_HALTED);

        // Reset during FLUSH: no residual flush/misalign afterwards
        resume = 1; cycle();
        jmp = 1; jmp_tgt = 16'h2001; cycle();
        rst = 1; cycle();
        lit("rst_flush", RESET_PC, 0, 0, 0, M_START);
        cycle(); lit("rst_flush_rel", RESET_PC, 1, 0, 0, M_RUN);

        // Reset during HALTED
        halt = 1; cycle();
        rst = 1; halt = 1; resume = 1; cycle();
        lit("rst_halted", RESET_PC, 0, 0, 0, M_START);
        halt = 1; cycle();
        lit("start_halt", RESET_PC, 0, 0, 0, M_HALTED);
        resume = 1; cycle();

        // Mixed request sequence, checked against the model every cycle
        for (int i = 0; i < 300; i++) begin
            rst      = ($urandom_range(0, 49) == 0);
            stall    = ($urandom_range(0, 3) == 0);
            halt     = ($urandom_range(0, 9) == 0);
            resume   = ($urandom_range(0, 2) == 0);
            br_taken = ($urandom_range(0, 4) == 0);
            br_off   = 16'($urandom_range(0, 65535));
            jmp      = ($urandom_range(0, 6) == 0);
            jmp_tgt  = 16'($urandom_range(0, 65535));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1);
    end

endmodule
